// File: rtl/mesh_term_arbiter.sv
// mesh_term_arbiter: round-robin injection arbiter that feeds one mesh terminal
// input port from NUM_REQ local packet sources. One packet is held in a holding
// register and offered on pndng_o/data_o until the router pops it (popin_i).
// A sticky timeout flag is raised when the router leaves an offer unpopped too long.
// Optional feature macro: ARB_STATS_EN adds saturating per-requester grant counters
// on grant_cnt_o.
module mesh_term_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PAKG_SIZE = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*PAKG_SIZE-1:0] req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic                         pndng_o,
    output logic [PAKG_SIZE-1:0]         data_o,
    input  logic                         popin_i,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_o,
    output logic                         timeout_o
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]        grant_cnt_o
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WCW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [PAKG_SIZE-1:0] data_q, data_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [IDW-1:0]       last_q, last_d;
    logic [WCW-1:0]       wait_q, wait_d;
    logic                 timeout_q, timeout_d;

    logic [IDW-1:0]       win_idx;
    logic [IDW-1:0]       cand;
    logic                 win_found;
    logic                 capture;
    logic [PAKG_SIZE-1:0] win_data;

    // Round-robin search starting one past the last winner; first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDW'((int'(last_q) + i) % NUM_REQ);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Select the winner's packet; only feeds the holding register, never the ready path.
    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == IDW'(k)) begin
                win_data = req_data_i[k*PAKG_SIZE +: PAKG_SIZE];
            end
        end
    end

    // A capture may happen when the holding register is empty or is being popped this cycle.
    assign capture = win_found && ((state_q == IDLE) || popin_i);

    // One-hot ready to the winner; forced low while reset is asserted.
    always_comb begin
        req_ready_o = '0;
        if (rst_i && capture) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    // Next-state logic: capture/retire the held packet and track unpopped offer cycles.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        wait_d     = wait_q;
        timeout_d  = timeout_q;

        if (capture) begin
            state_d    = OFFER;
            data_d     = win_data;
            grant_id_d = win_idx;
            last_d     = win_idx;
        end else if ((state_q == OFFER) && popin_i) begin
            state_d = IDLE;
        end

        // The flag rises on the edge at which the count of unpopped offer cycles
        // reaches TIMEOUT; the counter saturates there and the offer continues.
        if ((state_q == OFFER) && !popin_i) begin
            if (wait_q != WCW'(TIMEOUT)) begin
                wait_d = wait_q + 1'b1;
            end
            if (wait_q >= WCW'(TIMEOUT - 1)) begin
                timeout_d = 1'b1;
            end
        end else begin
            wait_d = '0;
        end
    end

    // State and holding registers; reset discards any held packet immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            data_q     <= '0;
            grant_id_q <= '0;
            last_q     <= IDW'(NUM_REQ - 1);
            wait_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
        end
    end

    assign pndng_o    = (state_q == OFFER);
    assign data_o     = data_q;
    assign grant_id_o = grant_id_q;
    assign timeout_o  = timeout_q;

`ifdef ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;

    // Per-requester grant counters, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (capture && (win_idx == IDW'(k)) && (cnt_q[k] != 16'hFFFF)) begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_mesh_term_arbiter.sv
// Testbench for mesh_term_arbiter: directed stimulus pushes expected packets into a
// queue; a monitor pops and compares on every pop handshake seen at the router side.
module tb_mesh_term_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int PAKG_SIZE = 32;
    localparam int TIMEOUT   = 8;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    logic                         clk = 1'b0;
    logic                         rst_i = 1'b0;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*PAKG_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready_o;
    logic                         pndng_o;
    logic [PAKG_SIZE-1:0]         data_o;
    logic                         popin;
    logic [1:0]                   grant_id_o;
    logic                         timeout_o;
`ifdef ARB_STATS_EN
    logic [NUM_REQ*16-1:0]        grant_cnt_o;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    mesh_term_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .PAKG_SIZE(PAKG_SIZE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_valid_i(req_valid),
        .req_data_i (req_data),
        .req_ready_o(req_ready_o),
        .pndng_o    (pndng_o),
        .data_o     (data_o),
        .popin_i    (popin),
        .grant_id_o (grant_id_o),
        .timeout_o  (timeout_o)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt_o(grant_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [31:0] d);
        exp_t e;
        e.id   = 2'(id);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: a pop happens at the next rising edge whenever pndng_o and popin are high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_i && pndng_o && popin) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop actual id=%0d data=%0h required no packet",
                             grant_id_o, data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_id", 64'(grant_id_o), 64'(e.id));
                    check("pop_data", 64'(data_o), 64'(e.data));
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        req_valid = '0;
        req_data  = '0;
        popin     = 1'b0;
        rst_i     = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        check("rst_pndng", 64'(pndng_o), 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd0);
        check("rst_timeout", 64'(timeout_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_grant_id", 64'(grant_id_o), 64'd0);

        // Single packet from requester 2, popped 3 cycles after pndng rises
        rst_i = 1'b1;
        step();
        req_data[2*32 +: 32] = 32'hA5A5_0123;
        req_valid = 4'b0100;
        push(2, 32'hA5A5_0123);
        #1;
        check("single_ready", 64'(req_ready_o), 64'h4);
        step();
        req_valid = '0;
        req_data  = '0;
        #1;
        check("single_pndng", 64'(pndng_o), 64'd1);
        check("single_data", 64'(data_o), 64'hA5A5_0123);
        for (int i = 0; i < 2; i++) begin
            step();
            check("single_hold_data", 64'(data_o), 64'hA5A5_0123);
            check("single_hold_pndng", 64'(pndng_o), 64'd1);
        end
        popin = 1'b1;
        step();
        popin = 1'b0;
        check("single_drop", 64'(pndng_o), 64'd0);
        check("single_consumed", 64'(exp_q.size()), 64'd0);

        // Skip idle requesters: last winner was 2, so order is 3,1,3,1
        req_data[1*32 +: 32] = 32'h1111_0001;
        req_data[3*32 +: 32] = 32'h3333_0003;
        req_valid = 4'b1010;
        popin = 1'b1;
        push(3, 32'h3333_0003);
        push(1, 32'h1111_0001);
        push(3, 32'h3333_0003);
        push(1, 32'h1111_0001);
        #1;
        check("skip_first_ready", 64'(req_ready_o), 64'h8);
        for (int i = 0; i < 4; i++) begin
            step();
            check("skip_ready_0_2", 64'(req_ready_o & 4'b0101), 64'd0);
            check("skip_pndng", 64'(pndng_o), 64'd1);
        end
        req_valid = '0;
        step();
        popin = 1'b0;
        check("skip_drop", 64'(pndng_o), 64'd0);

        // Timeout with TIMEOUT=8: flag set after the 8th unpopped offer cycle
        req_data  = '0;
        req_data[0 +: 32] = 32'hDEAD_BEEF;
        req_valid = 4'b0001;
        push(0, 32'hDEAD_BEEF);
        step();
        req_valid = '0;
        req_data  = '0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 7) check("timeout_before", 64'(timeout_o), 64'd0);
            if (i == 8) check("timeout_rise", 64'(timeout_o), 64'd1);
        end
        repeat (3) step();
        check("timeout_still_pndng", 64'(pndng_o), 64'd1);
        check("timeout_data_intact", 64'(data_o), 64'hDEAD_BEEF);
        popin = 1'b1;
        step();
        popin = 1'b0;
        check("timeout_sticky", 64'(timeout_o), 64'd1);
        check("timeout_drop", 64'(pndng_o), 64'd0);

        // Mid-offer asynchronous reset discards the held packet
        req_data[0 +: 32] = 32'hCAFE_F00D;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b1111;
        #1;
        check("midrst_pndng_before", 64'(pndng_o), 64'd1);
        check("midrst_ready_offer", 64'(req_ready_o), 64'd0);
        rst_i = 1'b0;
        #1;
        check("midrst_pndng", 64'(pndng_o), 64'd0);
        check("midrst_ready", 64'(req_ready_o), 64'd0);
        check("midrst_timeout", 64'(timeout_o), 64'd0);
        step();
        step();
        rst_i = 1'b1;
        #1;
        check("post_rst_ready", 64'(req_ready_o), 64'h1);

        // Fairness: all requesters valid, pop every cycle, 40 grants 0,1,2,3,...
        for (int k = 0; k < NUM_REQ; k++) req_data[k*32 +: 32] = 32'hF000_0000 + 32'(k);
        popin = 1'b1;
        for (int i = 0; i < 40; i++) push(i % 4, 32'hF000_0000 + 32'(i % 4));
        for (int i = 0; i < 40; i++) begin
            step();
            check("fair_pndng", 64'(pndng_o), 64'd1);
        end
        req_valid = '0;
        step();
        popin = 1'b0;
        check("fair_drop", 64'(pndng_o), 64'd0);
`ifdef ARB_STATS_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            check("grant_cnt", 64'(grant_cnt_o[k*16 +: 16]), 64'd10);
        end
`endif

        repeat (3) step();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mesh_term_arbiter.md
# mesh_term_arbiter

Round-robin injection arbiter that shares one terminal input port of the `mesh_gnrtr` mesh among `NUM_REQ` local packet sources. The arbiter latches one winning packet, presents it to the mesh through the terminal `pndng_i_in`/`data_out_i_in`/`popin` handshake, and holds it stable until the router pops it. It also flags a router that never pops. One instance sits between the traffic sources of a terminal and the matching mesh terminal slot.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `PAKG_SIZE`, 32: packet width in bits, same as the mesh `pckg_sz`.
- `TIMEOUT`, 1024: number of `OFFER` cycles without `popin_i` before a timeout is flagged; must be ≥ 2.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `req_valid_i` in `NUM_REQ`: requester *k* has a packet.
- `req_data_i` in `NUM_REQ*PAKG_SIZE`: packet of requester *k* at bits [k*PAKG_SIZE +: PAKG_SIZE].
- `req_ready_o` out `NUM_REQ`: one-hot; a transfer happens on `req_valid_i[k] & req_ready_o[k]` at a rising edge.
- `pndng_o` out 1: drives the mesh terminal `pndng_i_in`.
- `data_o` out `PAKG_SIZE`: drives the mesh terminal `data_out_i_in`.
- `popin_i` in 1: the mesh terminal `popin` output.
- `grant_id_o` out `$clog2(NUM_REQ)`: source index of the packet currently held.
- `timeout_o` out 1: sticky timeout flag.
- `grant_cnt_o` out `NUM_REQ*16`: per-requester grant counters. Present only with `ARB_STATS_EN`.

## Operation
- There are two states. `IDLE` means the holding register is empty. `OFFER` means the holding register is full and `pndng_o` = 1.
- Round-robin pointer `last`:
  - The search order is `last+1`, `last+2`, … modulo `NUM_REQ`.
  - The first requester with `req_valid_i` set wins.
  - `last` is set to the winner on every capture.
- **Capture** is allowed in `IDLE`, or in `OFFER` in the same cycle that `popin_i` = 1.
  - `req_ready_o[winner]` = 1 combinationally; all other ready bits are 0.
  - At the edge: the holding register ← `req_data_i[winner]`, `grant_id_o` ← winner, state ← `OFFER`.
- `IDLE` → `OFFER` on capture; otherwise the block stays in `IDLE`.
- In `OFFER`, when `popin_i` = 1:
  - If some requester has `req_valid_i` set, the block captures again and stays in `OFFER` (back-to-back, one packet per cycle).
  - Otherwise it goes to `IDLE`.
- In `OFFER` with `popin_i` = 0:
  - `data_o`, `grant_id_o` and `pndng_o` hold stable.
  - All `req_ready_o` = 0.
- Packets are never withdrawn or altered; the block does not interpret packet contents.
- Wait counter:
  - Counts consecutive `OFFER` cycles with `popin_i` = 0.
  - Clears on a pop or on leaving `OFFER`.
  - When it reaches `TIMEOUT`, `timeout_o` ← 1 and stays set until reset.
  - The offer continues after a timeout.
- In `IDLE`, `popin_i` is ignored.

## Timing
- Reset values (asynchronous, while `rst_i` = 0):
  - state = `IDLE`
  - `pndng_o` = 0, `data_o` = 0, `grant_id_o` = 0
  - `req_ready_o` = 0, `timeout_o` = 0
  - wait counter = 0, `last` = `NUM_REQ-1` (requester 0 wins first)
  - `grant_cnt_o` = 0
- Latency:
  - A `req_valid_i` seen in `IDLE` gives `pndng_o` = 1 on the next cycle.
  - A pop in `OFFER` with nothing pending drops `pndng_o` on the next cycle.
- All outputs except `req_ready_o` are registered.
- `req_ready_o` is combinational from `req_valid_i`, state, `popin_i` and `last`; it must not depend on `req_data_i`.
- Mid-operation reset: a held packet is discarded without being popped; `pndng_o` falls immediately.
- Simultaneous pop and new request: the pop retires the old packet and the new one is captured on the same edge; `pndng_o` stays high.
- A requester that deasserts `req_valid_i` before it is granted loses nothing and keeps no priority.

## Configuration
- `ARB_STATS_EN` defined:
  - `grant_cnt_o` exists.
  - Counter *k* increments on each capture from requester *k*.
  - Counters saturate at 16'hFFFF.
  - Counters reset to 0.
- `ARB_STATS_EN` undefined: the counters and the `grant_cnt_o` port are omitted. All other behaviour is identical.

## Test plan
- **Reset:** drive `rst_i` = 0 mid-`OFFER` with `pndng_o` = 1 → `pndng_o`, `req_ready_o`, `timeout_o` go to 0 without waiting for an edge. After release, requester 0 wins first.
- **Fairness:** all 4 `req_valid_i` held high, `popin_i` = 1 every cycle → `grant_id_o` sequence 0,1,2,3,0,… and `pndng_o` stays high continuously. With `ARB_STATS_EN`, after 40 grants every counter = 10.
- **Single packet:** requester 2 sends 32'hA5A5_0123 once, router pops 3 cycles after `pndng_o` rises → `data_o` is stable for those cycles. Exactly one `popin_i` is consumed, then `pndng_o` = 0.
- **Skip idle requesters:** only requesters 1 and 3 are valid → grants alternate 1,3,1,3. `req_ready_o[0]` and `req_ready_o[2]` never assert.
- **Timeout:** `TIMEOUT` = 8, `popin_i` held 0 → `timeout_o` rises on the 8th `OFFER` cycle and stays 1 after a later pop. The packet is still delivered intact.
- **Mesh integration:** 4×4 `mesh_gnrtr`, `PAKG_SIZE` = 32, `FIFO_DEPTH` = 16, 4 sources × 20 packets into terminal 0 → all 80 packets reach the destinations given in their headers, with no loss or duplication.
